// File: rtl/ipf_psum_acc_if.sv
// Product-bundle input and finished-sum output channel of the partial-sum accumulator.
`timescale 1ns/1ps
interface ipf_psum_acc_if #(
  parameter int unsigned NCUBE  = 8,
  parameter int unsigned NPROD  = 9,
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
);
  logic [NCUBE*NPROD*PROD_W-1:0] prod_in;
  logic                          prod_valid;
  logic [NCUBE*ACC_W-1:0]        out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output prod_in, prod_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  prod_in, prod_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/ipf_psum_acc.sv
// Partial-sum accumulator: 2-stage adder tree per cube, saturating multi-pass
// accumulation, 2-entry output FIFO with sticky overflow on dropped groups.
`timescale 1ns/1ps
module ipf_psum_acc #(
  parameter int unsigned NCUBE  = 8,
  parameter int unsigned NPROD  = 9,
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [LEN_W-1:0] acc_len,
  ipf_psum_acc_if.slave    bus,
  output logic             overflow,
  output logic             busy
);
  localparam int unsigned NPART  = NPROD / 3;
  localparam int unsigned PART_W = PROD_W + 2;
  localparam int unsigned SUM_W  = PART_W + 2;
  localparam int unsigned ADD_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int unsigned DATA_W = NCUBE * ACC_W;

  logic [PART_W-1:0] part_d [NCUBE][NPART];
  logic [PART_W-1:0] part_q [NCUBE][NPART];
  logic [SUM_W-1:0]  sum_d  [NCUBE];
  logic [SUM_W-1:0]  sum_q  [NCUBE];
  logic              va_q, vb_q;

  logic [ACC_W-1:0]  acc_q  [NCUBE];
  logic [ACC_W-1:0]  acc_d  [NCUBE];
  logic [LEN_W-1:0]  pass_q, len_q;
  logic [LEN_W-1:0]  len_in, len_eff;
  logic              grp_last;
  logic [DATA_W-1:0] grp_data;

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] last_q;
  logic              wptr_q, rptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q;
  logic              grp_done, fifo_full, pop, push, drop;

  // Stage A adders: three 3-product partial sums per cube.
  always_comb begin
    for (int unsigned c = 0; c < NCUBE; c++) begin
      for (int unsigned k = 0; k < NPART; k++) begin
        part_d[c][k] = '0;
        for (int unsigned j = 0; j < 3; j++) begin
          part_d[c][k] = part_d[c][k]
                       + PART_W'(bus.prod_in[(c*NPROD + k*3 + j)*PROD_W +: PROD_W]);
        end
      end
    end
  end

  // Stage B adders: fold the partials into one sum per cube.
  always_comb begin
    for (int unsigned c = 0; c < NCUBE; c++) begin
      sum_d[c] = '0;
      for (int unsigned k = 0; k < NPART; k++) begin
        sum_d[c] = sum_d[c] + SUM_W'(part_q[c][k]);
      end
    end
  end

  // Adder-tree pipeline registers and valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q   <= 1'b0;
      vb_q   <= 1'b0;
      part_q <= '{default: '0};
      sum_q  <= '{default: '0};
    end else if (clear) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      va_q <= bus.prod_valid;
      vb_q <= va_q;
      if (bus.prod_valid) part_q <= part_d;
      if (va_q)           sum_q  <= sum_d;
    end
  end

  // Saturating accumulate, group-length selection and FIFO handshake decode.
  always_comb begin
    len_in   = (acc_len == '0) ? LEN_W'(1) : acc_len;
    // The first pass of a group uses the live length; later passes the latched one.
    len_eff  = (pass_q == '0) ? len_in : len_q;
    grp_last = ({1'b0, pass_q} + (LEN_W+1)'(1)) >= {1'b0, len_eff};
    grp_data = '0;
    for (int unsigned c = 0; c < NCUBE; c++) begin
      logic [ADD_W-1:0] tmp;
      tmp      = ADD_W'(acc_q[c]) + ADD_W'(sum_q[c]);
      acc_d[c] = (tmp[ADD_W-1:ACC_W] != '0) ? '1 : tmp[ACC_W-1:0];
      grp_data[c*ACC_W +: ACC_W] = acc_d[c];
    end
    grp_done  = vb_q && grp_last;
    fifo_full = (cnt_q == 2'd2);
    pop       = (cnt_q != 2'd0) && bus.out_ready;
    push      = grp_done && (!fifo_full || pop);
    drop      = grp_done && fifo_full && !pop;
    cnt_d     = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  // Accumulator lanes and pass counter; the group restarts even when its result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '{default: '0};
      pass_q <= '0;
      len_q  <= '0;
    end else if (clear) begin
      acc_q  <= '{default: '0};
      pass_q <= '0;
    end else if (vb_q) begin
      len_q <= len_eff;
      if (grp_last) begin
        acc_q  <= '{default: '0};
        pass_q <= '0;
      end else begin
        acc_q  <= acc_d;
        pass_q <= pass_q + LEN_W'(1);
      end
    end
  end

  // Output FIFO storage, pointers, held output word and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      last_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= grp_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        last_q <= mem_q[rptr_q];
        rptr_q <= ~rptr_q;
      end
      if (drop) ovf_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Head of the FIFO when occupied, otherwise the most recently consumed word.
  always_comb begin
    bus.out_data  = (cnt_q != 2'd0) ? mem_q[rptr_q] : last_q;
    bus.out_valid = (cnt_q != 2'd0);
    overflow      = ovf_q;
    busy          = va_q || vb_q || (pass_q != '0) || (cnt_q != 2'd0);
  end
endmodule

// File: tb/tb_ipf_psum_acc.sv
// Scoreboard bench for ipf_psum_acc: a 24-bit and a 20-bit accumulator instance
// share stimulus; a lane model pushes expected groups, monitors pop on handshake.
`timescale 1ns/1ps
module tb_ipf_psum_acc;
  localparam int unsigned NCUBE = 8;
  localparam int unsigned NPROD = 9;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst, clear;
  logic [LEN_W-1:0] acc_len;
  logic             ovf24, busy24, ovf20, busy20;

  ipf_psum_acc_if #(.NCUBE(NCUBE), .NPROD(NPROD), .PROD_W(PROD_W), .ACC_W(24)) bus24 ();
  ipf_psum_acc_if #(.NCUBE(NCUBE), .NPROD(NPROD), .PROD_W(PROD_W), .ACC_W(20)) bus20 ();

  ipf_psum_acc #(.NCUBE(NCUBE), .NPROD(NPROD), .PROD_W(PROD_W), .ACC_W(24), .LEN_W(LEN_W)) dut24 (
    .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len),
    .bus(bus24), .overflow(ovf24), .busy(busy24));

  ipf_psum_acc #(.NCUBE(NCUBE), .NPROD(NPROD), .PROD_W(PROD_W), .ACC_W(20), .LEN_W(LEN_W)) dut20 (
    .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len),
    .bus(bus20), .overflow(ovf20), .busy(busy20));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference lane model
  int unsigned   m24 [NCUBE];
  int unsigned   m20 [NCUBE];
  int unsigned   m_pass, m_len;
  logic [191:0]  q24 [$];
  logic [159:0]  q20 [$];
  bit            chk20 = 1'b0;

  task automatic reset_model();
    for (int c = 0; c < NCUBE; c++) begin
      m24[c] = 0;
      m20[c] = 0;
    end
    m_pass = 0;
    q24.delete();
    q20.delete();
  endtask

  task automatic set_ready(input logic r);
    bus24.out_ready = r;
    bus20.out_ready = r;
  endtask

  // One beat: every product of cube c equals base + step*c.
  task automatic beat(input int unsigned base, input int unsigned step, input bit drop);
    logic [NCUBE*NPROD*PROD_W-1:0] pin;
    logic [191:0] e24;
    logic [159:0] e20;
    int unsigned  v, s;
    pin = '0;
    for (int c = 0; c < NCUBE; c++)
      for (int j = 0; j < NPROD; j++)
        pin[(c*NPROD + j)*PROD_W +: PROD_W] = 16'(base + step*c);
    bus24.prod_in = pin;  bus20.prod_in = pin;
    bus24.prod_valid = 1'b1;  bus20.prod_valid = 1'b1;
    if (m_pass == 0) m_len = (acc_len == 0) ? 1 : int'(acc_len);
    for (int c = 0; c < NCUBE; c++) begin
      v = (base + step*c) & 32'hFFFF;
      s = v * NPROD;
      m24[c] = (m24[c] + s > 32'hFFFFFF) ? 32'hFFFFFF : m24[c] + s;
      m20[c] = (m20[c] + s > 32'hFFFFF)  ? 32'hFFFFF  : m20[c] + s;
    end
    if (m_pass + 1 < m_len) begin
      m_pass++;
    end else begin
      for (int c = 0; c < NCUBE; c++) begin
        e24[c*24 +: 24] = 24'(m24[c]);
        e20[c*20 +: 20] = 20'(m20[c]);
        m24[c] = 0;
        m20[c] = 0;
      end
      if (!drop) begin
        q24.push_back(e24);
        q20.push_back(e20);
      end
      m_pass = 0;
    end
    @(posedge clk); #1;
    bus24.prod_valid = 1'b0;  bus20.prod_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    reset_model();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q24.size() != 0 || (chk20 && q20.size() != 0)); i++)
      @(negedge clk);
    #1;
    check("drain24", q24.size(), 0);
    if (chk20) check("drain20", q20.size(), 0);
  endtask

  // Scoreboard monitors: compare on every accepted output word.
  always @(negedge clk) begin
    if (!rst && bus24.out_valid && bus24.out_ready) begin
      if (q24.size() == 0) check("spurious24", bus24.out_valid, 1'b0);
      else                 check("lane24", bus24.out_data, q24.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk20 && !rst && bus20.out_valid && bus20.out_ready) begin
      if (q20.size() == 0) check("spurious20", bus20.out_valid, 1'b0);
      else                 check("lane20", bus20.out_data, q20.pop_front());
    end
  end

  initial begin
    rst = 1'b1;  clear = 1'b0;  acc_len = 4'd1;
    bus24.prod_in = '0;  bus20.prod_in = '0;
    bus24.prod_valid = 1'b0;  bus20.prod_valid = 1'b0;
    set_ready(1'b0);
    reset_model();
    #12;
    check("rst_valid", bus24.out_valid, 0);
    check("rst_busy", busy24, 0);
    check("rst_ovf", ovf24, 0);
    check("rst_data", bus24.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single-pass latency and per-cube sums
    acc_len = 4'd1;
    set_ready(1'b1);
    beat(1, 1, 0);
    @(negedge clk); check("t1_lat1", bus24.out_valid, 0);
    @(negedge clk); check("t1_lat2", bus24.out_valid, 0);
    @(negedge clk); check("t1_lat3", bus24.out_valid, 1);
    @(negedge clk); check("t1_pulse", bus24.out_valid, 0);
    drain();

    // 2: three-pass group of full-scale products
    acc_len = 4'd3;
    beat(32'hFFFF, 0, 0);
    beat(32'hFFFF, 0, 0);
    repeat (3) @(negedge clk);
    check("t2_noval", bus24.out_valid, 0);
    check("t2_busy", busy24, 1);
    beat(32'hFFFF, 0, 0);
    for (int i = 0; i < 10 && !bus24.out_valid; i++) @(negedge clk);
    check("t2_valid", bus24.out_valid, 1);
    @(negedge clk); check("t2_idle", busy24, 0);
    drain();

    // 3: FIFO overrun drops the third group
    acc_len = 4'd1;
    set_ready(1'b0);
    beat(1, 0, 0);
    beat(2, 0, 0);
    beat(3, 0, 1);
    repeat (5) @(negedge clk);
    check("t3_ovf", ovf24, 1);
    check("t3_full", bus24.out_valid, 1);
    set_ready(1'b1);
    drain();
    check("t3_ovf_sticky", ovf24, 1);
    do_clear();
    check("t3_ovf_clr", ovf24, 0);

    // 4: completion into a full FIFO while it pops
    set_ready(1'b0);
    beat(4, 0, 0);
    beat(5, 0, 0);
    repeat (4) @(negedge clk);
    check("t4_full", bus24.out_valid, 1);
    beat(6, 0, 0);
    @(posedge clk); #1;
    set_ready(1'b1);
    drain();
    check("t4_noovf", ovf24, 0);

    // 5: clear mid-group, then a length change after the group length is latched
    acc_len = 4'd4;
    beat(2, 0, 0);
    beat(2, 0, 0);
    do_clear();
    beat(1, 0, 0);
    beat(1, 0, 0);
    beat(1, 0, 0);
    acc_len = 4'd2;
    beat(1, 0, 0);
    drain();
    check("t5_idle", busy24, 0);

    // 6: 20-bit saturation, then asynchronous reset mid-group
    do_clear();
    chk20 = 1'b1;
    acc_len = 4'd3;
    beat(32'hFFFF, 0, 0);
    beat(32'hFFFF, 0, 0);
    beat(32'hFFFF, 0, 0);
    drain();
    set_ready(1'b0);
    acc_len = 4'd1;
    beat(1, 0, 0);
    beat(2, 0, 0);
    beat(3, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    acc_len = 4'd3;
    beat(1, 0, 0);
    repeat (2) @(negedge clk);
    check("t6_pre_val", bus20.out_valid, 1);
    check("t6_pre_ovf", ovf20, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t6_rst_val", bus20.out_valid, 0);
    check("t6_rst_ovf", ovf20, 0);
    check("t6_rst_busy", busy20, 0);
    check("t6_rst_busy24", busy24, 0);
    check("t6_rst_data", bus24.out_data, 0);
    reset_model();
    @(posedge clk); #1;
    rst = 1'b0;
    acc_len = 4'd1;
    set_ready(1'b1);
    beat(7, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
